// File: rtl/select_action_multi_if.sv
// Handshake and memory-write bundle for select_action_multi.
// master drives the request side; slave is the selector itself.
interface select_action_multi_if #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_SINKS  = 4
);
    logic                            en;
    logic                            start;
    logic [WORD_WIDTH-1:0]           nexthop;
    logic [NUM_SINKS*WORD_WIDTH-1:0] nextsinks;
    logic [WORD_WIDTH-1:0]           action;
    logic [WORD_WIDTH-1:0]           address;
    logic [WORD_WIDTH-1:0]           data_out;
    logic                            wr_en;
    logic                            forAggregation;
    logic                            done;

    modport master (
        output en, start, nexthop, nextsinks,
        input  action, address, data_out, wr_en, forAggregation, done
    );

    modport slave (
        input  en, start, nexthop, nextsinks,
        output action, address, data_out, wr_en, forAggregation, done
    );
endinterface

// File: rtl/select_action_multi.sv
// Forwarding-action selector: first valid in-cluster sink overrides the best next hop;
// a SELF_ID result posts the aggregation flag. Define SELECT_ACTION_WB_EN to also write back the action.
module select_action_multi #(
    parameter int WORD_WIDTH   = 16,
    parameter int NUM_SINKS    = 4,
    parameter int INVALID_SINK = 65,
    parameter int SELF_ID      = 300,
    parameter int FLAG_ADDR    = 2,
    parameter int ACTION_ADDR  = 3
) (
    input  logic                 clock,
    input  logic                 nrst,
    select_action_multi_if.slave bus
);
    localparam int IDX_W = (NUM_SINKS > 1) ? $clog2(NUM_SINKS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_SINKS - 1);
    localparam logic [WORD_WIDTH-1:0] INVALID  = WORD_WIDTH'(INVALID_SINK);
    localparam logic [WORD_WIDTH-1:0] SELF     = WORD_WIDTH'(SELF_ID);
    localparam logic [WORD_WIDTH-1:0] FLAG_A   = WORD_WIDTH'(FLAG_ADDR);
`ifdef SELECT_ACTION_WB_EN
    localparam logic [WORD_WIDTH-1:0] ACTION_A = WORD_WIDTH'(ACTION_ADDR);
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WB    = 3'd4,
        ST_WREND = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    state_t                          state_reg, state_next;
    logic [IDX_W-1:0]                idx_reg, idx_next;
    logic [NUM_SINKS*WORD_WIDTH-1:0] sinks_reg, sinks_next;
    logic [WORD_WIDTH-1:0]           action_reg, action_next;
    logic [WORD_WIDTH-1:0]           address_reg, address_next;
    logic [WORD_WIDTH-1:0]           data_out_reg, data_out_next;
    logic                            wr_en_reg, wr_en_next;
    logic                            for_agg_reg, for_agg_next;
    logic                            done_reg, done_next;

    // Slot view of the latched candidates; slot 0 is the highest priority.
    logic [WORD_WIDTH-1:0] slot [NUM_SINKS];
    generate
        for (genvar gi = 0; gi < NUM_SINKS; gi++) begin : g_slot
            assign slot[gi] = sinks_reg[gi*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            sinks_reg    <= '0;
            action_reg   <= '0;
            address_reg  <= '0;
            data_out_reg <= '0;
            wr_en_reg    <= 1'b0;
            for_agg_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            sinks_reg    <= sinks_next;
            action_reg   <= action_next;
            address_reg  <= address_next;
            data_out_reg <= data_out_next;
            wr_en_reg    <= wr_en_next;
            for_agg_reg  <= for_agg_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        sinks_next    = sinks_reg;
        action_next   = action_reg;
        address_next  = address_reg;
        data_out_next = data_out_reg;
        wr_en_next    = wr_en_reg;
        for_agg_next  = for_agg_reg;
        done_next     = done_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.en) begin
                    done_next    = 1'b0;
                    wr_en_next   = 1'b0;
                    for_agg_next = 1'b0;
                    state_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.start) begin
                    action_next = bus.nexthop;
                    sinks_next  = bus.nextsinks;
                    idx_next    = '0;
                    state_next  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (slot[idx_reg] != INVALID) begin
                    action_next = slot[idx_reg];
                    state_next  = ST_CHECK;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = ST_CHECK;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            ST_CHECK: begin
                if (action_reg == SELF) begin
                    for_agg_next  = 1'b1;
                    address_next  = FLAG_A;
                    data_out_next = WORD_WIDTH'(1);
                    wr_en_next    = 1'b1;
`ifdef SELECT_ACTION_WB_EN
                    state_next    = ST_WB;
`else
                    state_next    = ST_WREND;
`endif
                end else begin
                    for_agg_next = 1'b0;
`ifdef SELECT_ACTION_WB_EN
                    state_next   = ST_WB;
`else
                    state_next   = ST_FIN;
`endif
                end
            end
`ifdef SELECT_ACTION_WB_EN
            ST_WB: begin
                address_next  = ACTION_A;
                data_out_next = action_reg;
                wr_en_next    = 1'b1;
                state_next    = ST_WREND;
            end
`endif
            ST_WREND: begin
                wr_en_next = 1'b0;
                state_next = ST_FIN;
            end
            ST_FIN: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.action         = action_reg;
    assign bus.address        = address_reg;
    assign bus.data_out       = data_out_reg;
    assign bus.wr_en          = wr_en_reg;
    assign bus.forAggregation = for_agg_reg;
    assign bus.done           = done_reg;
endmodule
